mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Sits between the core's instruction-fetch and load/store stages and the single-port synchronous byte RAM.
- The RAM has 1-cycle read latency: it samples the address on a clock edge and returns read data in the following cycle.
- Arbitrates the two requesters with round-robin priority.
- Turns each fetch request into an atomic two-byte read and returns a 16-bit instruction.
- Routes load data back to the load/store stage.

Parameters:
ADDR_W, 8, memory address width
DATA_W, 8, memory data width

Ports:
clk  in  1  clock, all state updates on the rising edge
rst  in  1  reset, asynchronous, active-low
if_req_valid  in  1  fetch request valid
if_req_ready  out  1  fetch request accepted this cycle
if_req_addr  in  ADDR_W  instruction address (byte 0)
if_rsp_valid  out  1  one-cycle pulse, instruction ready
if_rsp_instr  out  2*DATA_W  {mem[A], mem[A+1]}
ls_req_valid  in  1  load/store request valid
ls_req_ready  out  1  load/store request accepted this cycle
ls_req_we  in  1  1 = store, 0 = load
ls_req_addr  in  ADDR_W  data address
ls_req_wdata  in  DATA_W  store data
ls_rsp_valid  out  1  one-cycle pulse, load data ready
ls_rsp_rdata  out  DATA_W  load data
mem_addr  out  ADDR_W  RAM address
mem_wdata  out  DATA_W  RAM write data
mem_we  out  1  RAM write enable
mem_rdata  in  DATA_W  RAM read data, valid the cycle after its address

Behaviour:
- Reset (rst low, asynchronous):
  - state = IDLE; pending tag = NONE; last_grant = LS, so the first contested grant goes to fetch.
  - if_rsp_valid = 0, ls_rsp_valid = 0, if_rsp_instr = 0, ls_rsp_rdata = 0, byte0 register = 0.
  - While rst is low: both readies = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0.
- FSM states: IDLE and IF_SECOND.
- IDLE, granting:
  - Only one valid: that requester is granted.
  - Both valid: grant the requester that is not last_grant, then update last_grant.
  - No valid: mem_addr = 0, mem_we = 0.
  - Ready is combinational and high only in the granted cycle. It may depend on the other requester's valid.
  - A transfer occurs when valid and ready are both high.
  - The requester must hold its addr/data/we stable until accepted.
- Fetch grant at cycle T:
  - mem_addr = if_req_addr (A), mem_we = 0; the address is latched; tag <= IF0; state <= IF_SECOND.
- IF_SECOND at T+1:
  - Both readies = 0.
  - mem_addr = (A+1) mod 2^ADDR_W, so 0xFF wraps to 0x00.
  - byte0 <= mem_rdata; tag <= IF1; state <= IDLE.
- IF1 tag at T+2:
  - if_rsp_instr <= {byte0, mem_rdata}; if_rsp_valid pulses during T+3.
  - The port is free at T+2: a new grant may issue that cycle.
- Load grant at T:
  - mem_addr = ls_req_addr, mem_we = 0; tag <= LS.
  - At T+1: ls_rsp_rdata <= mem_rdata; ls_rsp_valid pulses during T+2.
- Store grant at T:
  - mem_addr = ls_req_addr, mem_wdata = ls_req_wdata, mem_we = 1 for exactly that cycle.
  - tag <= NONE; no response is generated.
- Response registers hold their last value when not pulsing.
- Back-to-back:
  - A new grant may issue every cycle except during IF_SECOND.
  - Responses stay correctly routed: the tag is a pipeline register advanced every cycle.
- There is no backpressure on responses; consumers must accept the pulse.
- Reset mid-operation: any in-flight fetch or load is dropped and no response pulse occurs. After release the block restarts from IDLE with fetch priority.
- Simultaneous same-address store then fetch: the store is granted first and the fetch reads the new data (the RAM write completes at that edge).

Test Plan:
1. mem[0x10]=0x0E, mem[0x11]=0x00; fetch 0x10 accepted at T -> mem_addr 0x10 at T, 0x11 at T+1; if_rsp_valid high only in T+3; if_rsp_instr=0x0E00.
2. mem[0xFF]=0x5F, mem[0x00]=0x50; fetch 0xFF -> second mem_addr 0x00; if_rsp_instr=0x5F50.
3. Store addr 0xE0 data 0x01, then load 0xE0 -> mem_we=1 for one cycle, no ls_rsp_valid for the store; load gives ls_rsp_valid at T+2 with ls_rsp_rdata=0x01.
4. Both valid held high from reset -> grants IF, LS, IF, LS ...; ls_req_ready=0 in every IF_SECOND cycle; each fetch and load gets exactly one response.
5. Fetch 0x08 followed by load 0x20 granted in the IF1 cycle -> if_rsp_valid and ls_rsp_valid in consecutive cycles with correct data; neither response receives the other's data.
6. Assert rst low during IF_SECOND, release 2 cycles later -> no if_rsp_valid, all outputs 0 during reset; next fetch completes normally.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter between instruction fetch and load/store for a single-port
// synchronous byte RAM; fetches become atomic two-byte reads returning a 16-bit word.
module mem_port_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req_valid,
  output logic                if_req_ready,
  input  logic [ADDR_W-1:0]   if_req_addr,
  output logic                if_rsp_valid,
  output logic [2*DATA_W-1:0] if_rsp_instr,
  input  logic                ls_req_valid,
  output logic                ls_req_ready,
  input  logic                ls_req_we,
  input  logic [ADDR_W-1:0]   ls_req_addr,
  input  logic [DATA_W-1:0]   ls_req_wdata,
  output logic                ls_rsp_valid,
  output logic [DATA_W-1:0]   ls_rsp_rdata,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic                mem_we,
  input  logic [DATA_W-1:0]   mem_rdata
);

  typedef enum logic       {IDLE, IF_SECOND} state_e;
  typedef enum logic [1:0] {TAG_NONE, TAG_IF0, TAG_IF1, TAG_LS} tag_e;
  typedef enum logic       {GNT_IF, GNT_LS} gnt_e;

  state_e              state_q, state_d;
  tag_e                tag_q, tag_d;
  gnt_e                last_q, last_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   byte0_q;
  logic                if_vld_q, ls_vld_q;
  logic [2*DATA_W-1:0] instr_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                gnt_if, gnt_ls;

  always_comb begin
    state_d      = state_q;
    tag_d        = TAG_NONE;
    last_d       = last_q;
    addr_d       = addr_q;
    gnt_if       = 1'b0;
    gnt_ls       = 1'b0;
    if_req_ready = 1'b0;
    ls_req_ready = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    mem_we       = 1'b0;
    case (state_q)
      IDLE: begin
        gnt_if = if_req_valid && (!ls_req_valid || last_q == GNT_LS);
        gnt_ls = ls_req_valid && !gnt_if;
        if (if_req_valid && ls_req_valid) last_d = gnt_if ? GNT_IF : GNT_LS;
        if (gnt_if) begin
          if_req_ready = 1'b1;
          mem_addr     = if_req_addr;
          addr_d       = if_req_addr;
          tag_d        = TAG_IF0;
          state_d      = IF_SECOND;
        end else if (gnt_ls) begin
          ls_req_ready = 1'b1;
          mem_addr     = ls_req_addr;
          if (ls_req_we) begin
            mem_we    = 1'b1;
            mem_wdata = ls_req_wdata;
          end else begin
            tag_d = TAG_LS;
          end
        end
      end
      IF_SECOND: begin
        // Address wraps naturally at the top of the address space.
        mem_addr = addr_q + 1'b1;
        tag_d    = TAG_IF1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Keep the RAM and requesters quiet while reset is held.
    if (!rst) begin
      if_req_ready = 1'b0;
      ls_req_ready = 1'b0;
      mem_addr     = '0;
      mem_wdata    = '0;
      mem_we       = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      tag_q    <= TAG_NONE;
      last_q   <= GNT_LS;
      addr_q   <= '0;
      byte0_q  <= '0;
      if_vld_q <= 1'b0;
      ls_vld_q <= 1'b0;
      instr_q  <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      tag_q    <= tag_d;
      last_q   <= last_d;
      addr_q   <= addr_d;
      if_vld_q <= (tag_q == TAG_IF1);
      ls_vld_q <= (tag_q == TAG_LS);
      if (tag_q == TAG_IF0) byte0_q <= mem_rdata;
      if (tag_q == TAG_IF1) instr_q <= {byte0_q, mem_rdata};
      if (tag_q == TAG_LS)  rdata_q <= mem_rdata;
    end
  end

  assign if_rsp_valid = if_vld_q;
  assign if_rsp_instr = instr_q;
  assign ls_rsp_valid = ls_vld_q;
  assign ls_rsp_rdata = rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural byte RAM and a
// cycle-stamped response scoreboard.
module tb_mem_port_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        if_req_valid, if_req_ready, if_rsp_valid;
  logic [7:0]  if_req_addr;
  logic [15:0] if_rsp_instr;
  logic        ls_req_valid, ls_req_ready, ls_req_we, ls_rsp_valid;
  logic [7:0]  ls_req_addr, ls_req_wdata, ls_rsp_rdata;
  logic [7:0]  mem_addr, mem_wdata, mem_rdata;
  logic        mem_we;

  mem_port_arbiter #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk(clk), .rst(rst),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_req_addr(if_req_addr),
    .if_rsp_valid(if_rsp_valid), .if_rsp_instr(if_rsp_instr),
    .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready), .ls_req_we(ls_req_we),
    .ls_req_addr(ls_req_addr), .ls_req_wdata(ls_req_wdata),
    .ls_rsp_valid(ls_rsp_valid), .ls_rsp_rdata(ls_rsp_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  logic [7:0] ram [256];
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  typedef struct { int due; logic [15:0] data; } exp_t;
  exp_t       if_q[$];
  exp_t       ls_q[$];
  logic [7:0] ref_mem [256];
  int checks = 0, errors = 0, cyc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_rsp();
    exp_t e;
    if (if_rsp_valid) begin
      if (if_q.size() == 0) chk("if_rsp_unexpected", {31'd0, if_rsp_valid}, 0);
      else begin
        e = if_q.pop_front();
        chk("if_rsp_cycle", cyc, e.due);
        chk("if_rsp_instr", {16'd0, if_rsp_instr}, {16'd0, e.data});
      end
    end else if (if_q.size() != 0 && if_q[0].due <= cyc) begin
      chk("if_rsp_missing", {31'd0, if_rsp_valid}, 1);
      void'(if_q.pop_front());
    end
    if (ls_rsp_valid) begin
      if (ls_q.size() == 0) chk("ls_rsp_unexpected", {31'd0, ls_rsp_valid}, 0);
      else begin
        e = ls_q.pop_front();
        chk("ls_rsp_cycle", cyc, e.due);
        chk("ls_rsp_rdata", {24'd0, ls_rsp_rdata}, {16'd0, e.data});
      end
    end else if (ls_q.size() != 0 && ls_q[0].due <= cyc) begin
      chk("ls_rsp_missing", {31'd0, ls_rsp_valid}, 1);
      void'(ls_q.pop_front());
    end
  endtask

  task automatic next();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    check_rsp();
  endtask

  task automatic drain(input int n);
    repeat (n) next();
  endtask

  task automatic do_fetch(input logic [7:0] a);
    logic [7:0] a1;
    int         n;
    exp_t       e;
    a1 = a + 8'd1;
    n  = 0;
    if_req_addr  = a;
    if_req_valid = 1'b1;
    #1;
    while (!if_req_ready && n < 8) begin next(); #1; n++; end
    chk("if_req_ready", {31'd0, if_req_ready}, 1);
    chk("fetch_mem_addr0", {24'd0, mem_addr}, {24'd0, a});
    chk("fetch_mem_we", {31'd0, mem_we}, 0);
    e.due = cyc + 3;
    e.data = {ref_mem[a], ref_mem[a1]};
    if_q.push_back(e);
    next();
    if_req_valid = 1'b0;
    #1;
    chk("fetch_mem_addr1", {24'd0, mem_addr}, {24'd0, a1});
    chk("if_second_if_ready", {31'd0, if_req_ready}, 0);
    chk("if_second_ls_ready", {31'd0, ls_req_ready}, 0);
  endtask

  task automatic do_ls(input logic we, input logic [7:0] a, input logic [7:0] d);
    int   n;
    exp_t e;
    n = 0;
    ls_req_we    = we;
    ls_req_addr  = a;
    ls_req_wdata = d;
    ls_req_valid = 1'b1;
    #1;
    while (!ls_req_ready && n < 8) begin next(); #1; n++; end
    chk("ls_req_ready", {31'd0, ls_req_ready}, 1);
    chk("ls_mem_addr", {24'd0, mem_addr}, {24'd0, a});
    chk("ls_mem_we", {31'd0, mem_we}, {31'd0, we});
    if (we) begin
      chk("store_mem_wdata", {24'd0, mem_wdata}, {24'd0, d});
      ref_mem[a] = d;
    end else begin
      e.due = cyc + 2;
      e.data = {8'd0, ref_mem[a]};
      ls_q.push_back(e);
    end
    next();
    ls_req_valid = 1'b0;
    #1;
    if (we) chk("store_we_one_cycle", {31'd0, mem_we}, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_if_ready"},  {31'd0, if_req_ready}, 0);
    chk({tag, "_ls_ready"},  {31'd0, ls_req_ready}, 0);
    chk({tag, "_mem_addr"},  {24'd0, mem_addr}, 0);
    chk({tag, "_mem_wdata"}, {24'd0, mem_wdata}, 0);
    chk({tag, "_mem_we"},    {31'd0, mem_we}, 0);
    chk({tag, "_if_vld"},    {31'd0, if_rsp_valid}, 0);
    chk({tag, "_ls_vld"},    {31'd0, ls_rsp_valid}, 0);
    chk({tag, "_instr"},     {16'd0, if_rsp_instr}, 0);
    chk({tag, "_rdata"},     {24'd0, ls_rsp_rdata}, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int st;
    exp_t e;
    rst = 1'b0;
    if_req_valid = 1'b1; if_req_addr = 8'h00;
    ls_req_valid = 1'b1; ls_req_we = 1'b1; ls_req_addr = 8'h33; ls_req_wdata = 8'h77;
    @(negedge clk);
    #1;
    check_reset_outputs("reset");
    if_req_valid = 1'b0; ls_req_valid = 1'b0; ls_req_we = 1'b0;
    drain(2);
    rst = 1'b1;

    // Basic fetch, then fetch at the top of the address space.
    do_ls(1'b1, 8'h10, 8'h0E);
    do_ls(1'b1, 8'h11, 8'h00);
    do_fetch(8'h10);
    drain(4);
    do_ls(1'b1, 8'hFF, 8'h5F);
    do_ls(1'b1, 8'h00, 8'h50);
    do_fetch(8'hFF);
    drain(4);

    // Store then load of the same byte.
    do_ls(1'b1, 8'hE0, 8'h01);
    do_ls(1'b0, 8'hE0, 8'h00);
    drain(3);

    // Store immediately followed by a fetch of the stored byte.
    do_ls(1'b1, 8'h40, 8'hAB);
    do_ls(1'b1, 8'h41, 8'hCD);
    do_ls(1'b1, 8'h40, 8'h12);
    do_fetch(8'h40);
    drain(4);

    // Contention from reset: IF, busy, LS, IF, busy, LS ...
    do_ls(1'b1, 8'h30, 8'h11);
    do_ls(1'b1, 8'h31, 8'h22);
    do_ls(1'b1, 8'h50, 8'h33);
    drain(2);
    rst = 1'b0;
    next();
    rst = 1'b1;
    if_req_addr = 8'h30; if_req_valid = 1'b1;
    ls_req_addr = 8'h50; ls_req_we = 1'b0; ls_req_valid = 1'b1;
    st = 0;
    for (int k = 0; k < 12; k++) begin
      #1;
      chk("rr_if_ready", {31'd0, if_req_ready}, (st == 0) ? 1 : 0);
      chk("rr_ls_ready", {31'd0, ls_req_ready}, (st == 2) ? 1 : 0);
      chk("rr_mem_addr", {24'd0, mem_addr}, (st == 0) ? 32'h30 : (st == 1) ? 32'h31 : 32'h50);
      if (st == 0) begin
        e.due = cyc + 3; e.data = {ref_mem[8'h30], ref_mem[8'h31]}; if_q.push_back(e);
      end else if (st == 2) begin
        e.due = cyc + 2; e.data = {8'd0, ref_mem[8'h50]}; ls_q.push_back(e);
      end
      st = (st + 1) % 3;
      next();
    end
    if_req_valid = 1'b0; ls_req_valid = 1'b0;
    drain(5);

    // Load granted in the cycle the fetch's second byte returns.
    do_ls(1'b1, 8'h08, 8'hA1);
    do_ls(1'b1, 8'h09, 8'hB2);
    do_ls(1'b1, 8'h20, 8'hC3);
    do_fetch(8'h08);
    do_ls(1'b0, 8'h20, 8'h00);
    drain(4);

    // Reset during IF_SECOND drops the fetch.
    do_ls(1'b1, 8'h60, 8'h9A);
    do_ls(1'b1, 8'h61, 8'hBC);
    do_fetch(8'h60);
    if_req_valid = 1'b1; ls_req_valid = 1'b1; ls_req_we = 1'b1;
    rst = 1'b0;
    #1;
    check_reset_outputs("midreset");
    if_q.delete();
    if_req_valid = 1'b0; ls_req_valid = 1'b0; ls_req_we = 1'b0;
    drain(2);
    rst = 1'b1;
    drain(3);
    do_fetch(8'h60);
    drain(4);

    chk("if_queue_empty", if_q.size(), 0);
    chk("ls_queue_empty", ls_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
